svc_rv_fv_mem: RTL and testbench
================================

Name: svc_rv_fv_mem

Overview:
Reusable formal/simulation memory model that sits directly downstream of the svc_rv core's imem/dmem ports. It supplies fetch data from a constant instruction image and load data from a free data source, with SRAM (0-cycle) or BRAM (1-cycle) timing. It also injects bounded, well-formed stalls. Solver-driven (or bench-driven) requests enter as raw inputs; the block clamps them to legal behaviour rather than relying on assumptions.

Parameters:
IMEM_WORDS, 32, instruction image depth in words (power of two); IMEM_AW = $clog2(IMEM_WORDS)
MEM_TYPE, 0, 0 = SRAM combinational read, 1 = BRAM registered read
STALL_EN, 0, 1 enables stall injection; 0 ties both stall outputs low
MAX_STALL, 2, maximum consecutive stalled cycles per port and across both ports combined (1..3)
NOP, 32'h00000013, fetch data during and after reset

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
imem_ren  in  1  fetch request
imem_raddr  in  32  fetch byte address
imem_rdata  out  32  fetch data
imem_stall  out  1  granted fetch stall
dmem_ren  in  1  load request
dmem_rdata  out  32  load data
dmem_stall  out  1  granted data stall
imem_image  in  32*IMEM_WORDS  instruction image; word i at bits [32*i+31:32*i]; held constant by the driver
dmem_rdata_src  in  32  free load-data source
imem_stall_req  in  1  raw fetch-stall request
dmem_stall_req  in  1  raw data-stall request

Behaviour:
- imem_idx = imem_raddr[IMEM_AW+1:2]. Addresses wrap modulo IMEM_WORDS. imem_raddr[1:0] is ignored.
- Counters imem_cnt, dmem_cnt, any_cnt: 2 bits each, reset 0.
  - Each counter increments (saturating at MAX_STALL) in a cycle where its stall is granted; any_cnt counts cycles where either stall is granted.
  - Each counter clears in any cycle where its stall is not granted.
- imem_pending: reset 0. Set when imem_ren=1. Otherwise cleared when imem_stall=0. Otherwise held.
- Grant rules (combinational; all forced 0 when reset=1 or STALL_EN=0):
  - dmem_stall = dmem_stall_req & (dmem_cnt<MAX_STALL) & (any_cnt<MAX_STALL)
  - imem_stall = imem_stall_req & imem_pending & (imem_cnt<MAX_STALL) & (any_cnt<MAX_STALL)
  - Simultaneous grants count as one any_cnt cycle.
- Load-data hold register dmem_held: reset 0. Loads dmem_rdata_src when dmem_ren & !dmem_stall.
- SRAM (MEM_TYPE=0):
  - imem_rdata = imem_ren ? imem_image[imem_idx] : NOP, same cycle.
  - dmem_rdata = dmem_stall ? dmem_held : (dmem_ren ? dmem_rdata_src : 0).
- BRAM (MEM_TYPE=1):
  - imem_q: reset NOP. Loads imem_image[imem_idx] when imem_ren & !imem_stall; otherwise holds. imem_rdata = imem_q.
  - dmem_q: reset 0. Loads dmem_rdata_src when dmem_ren & !dmem_stall; otherwise holds. dmem_rdata = dmem_q.
  - A stall never changes returned data.
- Reset values: imem_rdata = NOP, dmem_rdata = 0, both stalls = 0.
- Reset asserted mid-stall: counters and pending clear, and stalls drop in the same cycle.
- imem_stall without a pending fetch is never granted.
- No X is ever driven on any output.

Decomposition:
- Package svc_rv_fv_pkg: NOP_INSN constant and mem_type_e enum (MEM_SRAM=0, MEM_BRAM=1). The parameter defaults use these.
- Sub-module svc_rv_fv_stall_ctr (inputs grant, reset; output cnt; parameter MAX), instantiated three times (imem, dmem, any).
- Read-path muxing stays in the top level.

Test Plan:
1. SRAM, image word 3 = 0xDEADBEEF; imem_ren=1, raddr=0x0C -> imem_rdata=0xDEADBEEF same cycle. raddr=0x8C (wrap) -> same value. raddr=0x0E -> same value.
2. BRAM, reset released at cycle 0 -> imem_rdata=0x00000013. imem_ren with raddr=0x0C at cycle 2 -> 0xDEADBEEF from cycle 3, held while imem_ren=0.
3. STALL_EN=1, MAX_STALL=2, dmem_stall_req high 5 cycles -> dmem_stall = 1,1,0,1,1.
4. STALL_EN=1, imem_stall_req high from reset release with imem_ren=0 -> imem_stall=0. imem_ren pulse at cycle 4 -> imem_stall=1 at cycles 5-6, 0 at cycle 7.
5. BRAM, dmem_ren with src=0x1234 while dmem_stall=1 -> dmem_rdata unchanged. Stall drops with src=0x5678 -> dmem_rdata=0x5678 next cycle.
6. Both requests high with fetch pending -> both stalls 1 for 2 cycles, both 0 on the third (any_cnt bound). Assert reset during the second stalled cycle -> both stalls 0 immediately, imem_rdata=NOP next cycle (BRAM).

Source files
------------

// File: rtl/svc_rv_fv_pkg.sv
// Shared definitions for the svc_rv formal/simulation memory model.
//   NOP_INSN   : instruction returned while no fetch data is available (addi x0,x0,0)
//   mem_type_e : read timing of the modelled memories
package svc_rv_fv_pkg;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic {
        MEM_SRAM = 1'b0,
        MEM_BRAM = 1'b1
    } mem_type_e;

endpackage : svc_rv_fv_pkg

// File: rtl/svc_rv_fv_stall_ctr.sv
// Consecutive-stall counter.
// Counts cycles in which its stall is granted, saturating at MAX, and
// returns to zero on the first cycle without a grant.
//   clock : clock
//   reset : synchronous, active-high reset
//   grant : stall granted this cycle
//   cnt   : number of consecutive granted cycles so far (0..MAX)
module svc_rv_fv_stall_ctr #(
    parameter int MAX = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       grant,
    output logic [1:0] cnt
);

    localparam logic [1:0] MAX_CNT = 2'(MAX);

    // Saturating run-length counter of granted stall cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 2'd0;
        end else if (!grant) begin
            cnt <= 2'd0;
        end else if (cnt < MAX_CNT) begin
            cnt <= cnt + 2'd1;
        end else begin
            cnt <= cnt;
        end
    end

endmodule : svc_rv_fv_stall_ctr

// File: rtl/svc_rv_fv_mem.sv
// Memory model placed downstream of the svc_rv core's imem/dmem ports.
// Fetch data comes from a constant instruction image, load data from a free
// source, with SRAM (same-cycle) or BRAM (next-cycle) timing. Raw stall
// requests are clamped into bounded, well-formed stalls.
//   clock, reset          : clock, synchronous active-high reset
//   imem_ren/raddr        : fetch request and byte address
//   imem_rdata/imem_stall : fetch data and granted fetch stall
//   dmem_ren              : load request
//   dmem_rdata/dmem_stall : load data and granted load stall
//   imem_image            : flattened instruction image, word i at [32*i+31:32*i]
//   dmem_rdata_src        : free load-data source
//   imem/dmem_stall_req   : raw stall requests
module svc_rv_fv_mem
    import svc_rv_fv_pkg::*;
#(
    parameter int          IMEM_WORDS = 32,
    parameter int          MEM_TYPE   = int'(MEM_SRAM),
    parameter bit          STALL_EN   = 1'b0,
    parameter int          MAX_STALL  = 2,
    parameter logic [31:0] NOP        = NOP_INSN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     imem_ren,
    input  logic [31:0]              imem_raddr,
    output logic [31:0]              imem_rdata,
    output logic                     imem_stall,
    input  logic                     dmem_ren,
    output logic [31:0]              dmem_rdata,
    output logic                     dmem_stall,
    input  logic [32*IMEM_WORDS-1:0] imem_image,
    input  logic [31:0]              dmem_rdata_src,
    input  logic                     imem_stall_req,
    input  logic                     dmem_stall_req
);

    localparam int         IMEM_AW = $clog2(IMEM_WORDS);
    localparam logic [1:0] MAX_CNT = 2'(MAX_STALL);

    logic [31:0]        imem_words [IMEM_WORDS];
    logic [IMEM_AW-1:0] imem_idx;
    logic [31:0]        imem_word;
    logic [1:0]         imem_cnt;
    logic [1:0]         dmem_cnt;
    logic [1:0]         any_cnt;
    logic               any_grant;
    logic               imem_pending;
    logic [31:0]        imem_q;
    logic [31:0]        dmem_q;
    logic               unused_raddr;

    for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_unpack
        assign imem_words[i] = imem_image[32*i +: 32];
    end

    // Word index wraps modulo the image depth; byte offset is ignored.
    assign imem_idx     = imem_raddr[IMEM_AW+1:2];
    assign imem_word    = imem_words[imem_idx];
    assign unused_raddr = ^{imem_raddr[31:IMEM_AW+2], imem_raddr[1:0]};

    // Simultaneous grants advance the shared budget only once.
    assign any_grant = imem_stall | dmem_stall;

    svc_rv_fv_stall_ctr #(.MAX(MAX_STALL)) u_imem_ctr (
        .clock (clock),
        .reset (reset),
        .grant (imem_stall),
        .cnt   (imem_cnt)
    );

    svc_rv_fv_stall_ctr #(.MAX(MAX_STALL)) u_dmem_ctr (
        .clock (clock),
        .reset (reset),
        .grant (dmem_stall),
        .cnt   (dmem_cnt)
    );

    svc_rv_fv_stall_ctr #(.MAX(MAX_STALL)) u_any_ctr (
        .clock (clock),
        .reset (reset),
        .grant (any_grant),
        .cnt   (any_cnt)
    );

    // Stall grants: clamp raw requests to per-port and combined budgets;
    // reset drops both grants in the same cycle.
    always_comb begin
        imem_stall = 1'b0;
        dmem_stall = 1'b0;
        if (STALL_EN && !reset) begin
            dmem_stall = dmem_stall_req && (dmem_cnt < MAX_CNT) && (any_cnt < MAX_CNT);
            imem_stall = imem_stall_req && imem_pending &&
                         (imem_cnt < MAX_CNT) && (any_cnt < MAX_CNT);
        end else begin
            imem_stall = 1'b0;
            dmem_stall = 1'b0;
        end
    end

    // Fetch-pending flag: a fetch stall may only extend an outstanding fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            imem_pending <= 1'b0;
        end else if (imem_ren) begin
            imem_pending <= 1'b1;
        end else if (!imem_stall) begin
            imem_pending <= 1'b0;
        end else begin
            imem_pending <= imem_pending;
        end
    end

    // Registered fetch word (BRAM timing); a stalled fetch keeps the old word
    always_ff @(posedge clock) begin
        if (reset) begin
            imem_q <= NOP;
        end else if (imem_ren && !imem_stall) begin
            imem_q <= imem_word;
        end else begin
            imem_q <= imem_q;
        end
    end

    // Registered load word: BRAM read data and the SRAM stall hold value,
    // which follow identical load/hold rules
    always_ff @(posedge clock) begin
        if (reset) begin
            dmem_q <= 32'h0000_0000;
        end else if (dmem_ren && !dmem_stall) begin
            dmem_q <= dmem_rdata_src;
        end else begin
            dmem_q <= dmem_q;
        end
    end

    // Read-data muxing for the selected memory timing
    always_comb begin
        imem_rdata = NOP;
        dmem_rdata = 32'h0000_0000;
        if (MEM_TYPE == int'(MEM_BRAM)) begin
            imem_rdata = imem_q;
            dmem_rdata = dmem_q;
        end else if (reset) begin
            imem_rdata = NOP;
            dmem_rdata = 32'h0000_0000;
        end else begin
            imem_rdata = imem_ren ? imem_word : NOP;
            dmem_rdata = dmem_stall ? dmem_q :
                         (dmem_ren ? dmem_rdata_src : 32'h0000_0000);
        end
    end

endmodule : svc_rv_fv_mem

// File: tb/tb_svc_rv_fv_mem.sv
// Self-checking bench for svc_rv_fv_mem: three instances (SRAM with stalls,
// BRAM with stalls, defaults without stalls) share one stimulus stream and
// are compared every cycle against a cycle-level reference model.
module tb_svc_rv_fv_mem;

    localparam int          WORDS = 32;
    localparam int          MAXS  = 2;
    localparam logic [31:0] NOPV  = 32'h00000013;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  ren;
    logic [31:0]           raddr;
    logic                  dren;
    logic [31:0]           src;
    logic                  ireq;
    logic                  dreq;
    logic [32*WORDS-1:0]   image;
    logic [31:0]           img [WORDS];

    logic [31:0] sr_irdata, br_irdata, ns_irdata;
    logic [31:0] sr_drdata, br_drdata, ns_drdata;
    logic        sr_istall, br_istall, ns_istall;
    logic        sr_dstall, br_dstall, ns_dstall;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_icnt, m_dcnt, m_acnt;
    logic        m_pend;
    logic [31:0] m_iq, m_dq;

    // Values sampled at the last checked negedge
    logic        s_istall, s_dstall;

    always #5 clock = ~clock;

    svc_rv_fv_mem #(.IMEM_WORDS(WORDS), .MEM_TYPE(0), .STALL_EN(1'b1), .MAX_STALL(MAXS)) u_sram (
        .clock(clock), .reset(reset), .imem_ren(ren), .imem_raddr(raddr),
        .imem_rdata(sr_irdata), .imem_stall(sr_istall), .dmem_ren(dren),
        .dmem_rdata(sr_drdata), .dmem_stall(sr_dstall), .imem_image(image),
        .dmem_rdata_src(src), .imem_stall_req(ireq), .dmem_stall_req(dreq)
    );

    svc_rv_fv_mem #(.IMEM_WORDS(WORDS), .MEM_TYPE(1), .STALL_EN(1'b1), .MAX_STALL(MAXS)) u_bram (
        .clock(clock), .reset(reset), .imem_ren(ren), .imem_raddr(raddr),
        .imem_rdata(br_irdata), .imem_stall(br_istall), .dmem_ren(dren),
        .dmem_rdata(br_drdata), .dmem_stall(br_dstall), .imem_image(image),
        .dmem_rdata_src(src), .imem_stall_req(ireq), .dmem_stall_req(dreq)
    );

    svc_rv_fv_mem u_nostall (
        .clock(clock), .reset(reset), .imem_ren(ren), .imem_raddr(raddr),
        .imem_rdata(ns_irdata), .imem_stall(ns_istall), .dmem_ren(dren),
        .dmem_rdata(ns_drdata), .dmem_stall(ns_dstall), .imem_image(image),
        .dmem_rdata_src(src), .imem_stall_req(ireq), .dmem_stall_req(dreq)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v + 1 > MAXS) ? MAXS : v + 1;
    endfunction

    // One clock cycle: compare all outputs at the negedge against the model,
    // advance the model across the posedge, return just after the posedge.
    task automatic step();
        logic        gi, gd;
        logic [31:0] word, e_sri, e_srd, e_nsi, e_nsd;
        @(negedge clock);
        word = img[raddr[6:2]];
        gd = !reset && dreq && (m_dcnt < MAXS) && (m_acnt < MAXS);
        gi = !reset && ireq && m_pend && (m_icnt < MAXS) && (m_acnt < MAXS);
        e_sri = reset ? NOPV : (ren ? word : NOPV);
        e_srd = reset ? 32'h0 : (gd ? m_dq : (dren ? src : 32'h0));
        e_nsi = e_sri;
        e_nsd = reset ? 32'h0 : (dren ? src : 32'h0);
        s_istall = sr_istall;
        s_dstall = sr_dstall;
        check_val("sram_irdata", sr_irdata, e_sri);
        check_val("sram_drdata", sr_drdata, e_srd);
        check_val("sram_istall", {31'h0, sr_istall}, {31'h0, gi});
        check_val("sram_dstall", {31'h0, sr_dstall}, {31'h0, gd});
        check_val("bram_irdata", br_irdata, m_iq);
        check_val("bram_drdata", br_drdata, m_dq);
        check_val("bram_istall", {31'h0, br_istall}, {31'h0, gi});
        check_val("bram_dstall", {31'h0, br_dstall}, {31'h0, gd});
        check_val("nost_irdata", ns_irdata, e_nsi);
        check_val("nost_drdata", ns_drdata, e_nsd);
        check_val("nost_stalls", {30'h0, ns_istall, ns_dstall}, 32'h0);
        if (reset) begin
            m_icnt = 0; m_dcnt = 0; m_acnt = 0;
            m_pend = 1'b0; m_iq = NOPV; m_dq = 32'h0;
        end else begin
            m_icnt = gi ? sat_inc(m_icnt) : 0;
            m_dcnt = gd ? sat_inc(m_dcnt) : 0;
            m_acnt = (gi || gd) ? sat_inc(m_acnt) : 0;
            if (ren && !gi) m_iq = word;
            if (dren && !gd) m_dq = src;
            m_pend = ren || (m_pend && gi);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ren = 1'b0; raddr = 32'h0; dren = 1'b0; src = 32'h0;
        ireq = 1'b0; dreq = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0] pat;
        for (int i = 0; i < WORDS; i++) img[i] = $urandom;
        img[3] = 32'hDEADBEEF;
        for (int i = 0; i < WORDS; i++) image[32*i +: 32] = img[i];
        m_icnt = 0; m_dcnt = 0; m_acnt = 0;
        m_pend = 1'b0; m_iq = NOPV; m_dq = 32'h0;
        idle_inputs();
        do_reset(2);

        // Fetch addressing: exact, wrapped and unaligned byte addresses
        ren = 1'b1;
        raddr = 32'h0000_000C; step(); check_val("fetch_0c", sr_irdata, 32'hDEADBEEF);
        raddr = 32'h0000_008C; step(); check_val("fetch_8c", sr_irdata, 32'hDEADBEEF);
        raddr = 32'h0000_000E; step(); check_val("fetch_0e", sr_irdata, 32'hDEADBEEF);
        ren = 1'b0; step();
        check_val("bram_hold", br_irdata, 32'hDEADBEEF);
        step();

        // Data stall budget: 1,1,0,1,1
        pat = 5'b11011;
        dreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("dstall_seq", {31'h0, s_dstall}, {31'h0, pat[4-i]});
        end
        dreq = 1'b0; step();

        // Fetch stall needs a pending fetch
        do_reset(1);
        ireq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("istall_nopend", {31'h0, s_istall}, 32'h0);
        end
        ren = 1'b1; raddr = 32'h0000_0010; step();
        ren = 1'b0;
        pat = 5'b11000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("istall_seq", {31'h0, s_istall}, {31'h0, pat[4-i]});
        end
        ireq = 1'b0;

        // Stalled load keeps BRAM data; release loads the new source
        dreq = 1'b1; dren = 1'b1; src = 32'h0000_1234;
        step(); step();
        check_val("bram_dstall_keep", br_drdata, 32'h0);
        src = 32'h0000_5678; step();
        check_val("bram_dload", br_drdata, 32'h0000_5678);
        idle_inputs(); step();

        // Combined budget: both granted twice, then neither
        do_reset(1);
        ren = 1'b1; raddr = 32'h0000_000C; step();
        ren = 1'b0; ireq = 1'b1; dreq = 1'b1;
        pat = 5'b11000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("both_seq", {30'h0, s_istall, s_dstall}, {30'h0, pat[4-i], pat[4-i]});
        end
        idle_inputs();

        // Reset during the second stalled cycle
        do_reset(1);
        ren = 1'b1; raddr = 32'h0000_000C; step();
        ren = 1'b0; ireq = 1'b1; dreq = 1'b1;
        step();
        check_val("both_first", {30'h0, s_istall, s_dstall}, 32'h3);
        reset = 1'b1; step();
        check_val("both_rst", {30'h0, s_istall, s_dstall}, 32'h0);
        check_val("bram_rst_nop", br_irdata, NOPV);
        reset = 1'b0; idle_inputs(); step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            ren   = $urandom_range(0, 1) == 1;
            raddr = $urandom;
            dren  = $urandom_range(0, 1) == 1;
            src   = $urandom;
            ireq  = $urandom_range(0, 4) < 3;
            dreq  = $urandom_range(0, 4) < 3;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_svc_rv_fv_mem
